// File: rtl/sdram_access_arbiter.sv
// Two-port arbiter in front of the SDRAM controller: port A (VGA line reads, priority,
// outstanding-read limited) and port B (frame upload writes), with bounded grant lengths.
module sdram_access_arbiter #(
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 16,
  parameter int A_MAX_BEATS = 512,
  parameter int B_MAX_BEATS = 16,
  parameter int MAX_PENDING = 8
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iA_RD_EN,
  input  logic [ADDR_W-1:0] iA_RD_ADDR,
  output logic              oA_WAIT_REQUEST,
  output logic [DATA_W-1:0] oA_RD_DATA,
  output logic              oA_RD_DATAVALID,
  input  logic              iB_WR_EN,
  input  logic [ADDR_W-1:0] iB_WR_ADDR,
  input  logic [DATA_W-1:0] iB_WR_DATA,
  output logic              oB_WAIT_REQUEST,
  output logic              oSDRAM_RD,
  output logic              oSDRAM_WR,
  output logic [ADDR_W-1:0] oSDRAM_ADDR,
  output logic [DATA_W-1:0] oSDRAM_WDATA,
  input  logic              iSDRAM_WAIT_REQUEST,
  input  logic [DATA_W-1:0] iSDRAM_RD_DATA,
  input  logic              iSDRAM_RD_DATAVALID,
  output logic [1:0]        oGRANT,
  output logic [3:0]        oPENDING_RD
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_A = 2'd1,
    ST_GRANT_B = 2'd2,
    ST_SWITCH  = 2'd3
  } state_t;

  localparam logic [9:0] A_MAX    = 10'(A_MAX_BEATS);
  localparam logic [9:0] B_MAX    = 10'(B_MAX_BEATS);
  localparam logic [3:0] PEND_MAX = 4'(MAX_PENDING);

  state_t      state_q, state_d;
  logic        target_b_q, target_b_d;
  logic [9:0]  beat_q, beat_d;
  logic [3:0]  pending_q, pending_d;

  logic        throttle;
  logic [9:0]  beat_sat;
  logic        a_acc, b_acc;
  logic        sdram_rd, sdram_wr;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_wdata;
  logic        a_wait, b_wait;
  logic [1:0]  grant;

  assign throttle = (pending_q == PEND_MAX);
  assign beat_sat = (beat_q == 10'h3FF) ? beat_q : beat_q + 10'd1;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= ST_IDLE;
      target_b_q <= 1'b0;
      beat_q     <= '0;
      pending_q  <= '0;
    end else begin
      state_q    <= state_d;
      target_b_q <= target_b_d;
      beat_q     <= beat_d;
      pending_q  <= pending_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    target_b_d  = target_b_q;
    beat_d      = beat_q;
    pending_d   = pending_q;
    sdram_rd    = 1'b0;
    sdram_wr    = 1'b0;
    sdram_addr  = '0;
    sdram_wdata = '0;
    a_wait      = 1'b1;
    b_wait      = 1'b1;
    grant       = 2'b00;
    a_acc       = 1'b0;
    b_acc       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        beat_d = '0;
        if (iA_RD_EN) begin
          state_d = ST_GRANT_A;
        end else if (iB_WR_EN) begin
          state_d = ST_GRANT_B;
        end
      end

      ST_GRANT_A: begin
        grant    = 2'b01;
        sdram_rd = iA_RD_EN && !throttle;
        if (sdram_rd) begin
          sdram_addr = iA_RD_ADDR;
        end
        a_wait = throttle || iSDRAM_WAIT_REQUEST;
        a_acc  = sdram_rd && !iSDRAM_WAIT_REQUEST;
        if (a_acc) begin
          beat_d = beat_sat;
        end
        // Forced hand-over only on an accepted beat, so no pending command is dropped.
        if (!iA_RD_EN) begin
          if (iB_WR_EN) begin
            state_d    = ST_SWITCH;
            target_b_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (a_acc && (beat_sat == A_MAX) && iB_WR_EN) begin
          state_d    = ST_SWITCH;
          target_b_d = 1'b1;
        end
      end

      ST_GRANT_B: begin
        grant    = 2'b10;
        sdram_wr = iB_WR_EN;
        if (sdram_wr) begin
          sdram_addr  = iB_WR_ADDR;
          sdram_wdata = iB_WR_DATA;
        end
        b_wait = iSDRAM_WAIT_REQUEST;
        b_acc  = sdram_wr && !iSDRAM_WAIT_REQUEST;
        if (b_acc) begin
          beat_d = beat_sat;
        end
        if (!iB_WR_EN) begin
          if (iA_RD_EN) begin
            state_d    = ST_SWITCH;
            target_b_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (b_acc && (beat_sat == B_MAX) && iA_RD_EN) begin
          state_d    = ST_SWITCH;
          target_b_d = 1'b0;
        end
      end

      ST_SWITCH: begin
        beat_d  = '0;
        state_d = target_b_q ? ST_GRANT_B : ST_GRANT_A;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A simultaneous issue and return leave the outstanding count unchanged.
    case ({a_acc, iSDRAM_RD_DATAVALID})
      2'b10:   pending_d = pending_q + 4'd1;
      2'b01:   pending_d = (pending_q != 4'd0) ? pending_q - 4'd1 : pending_q;
      default: pending_d = pending_q;
    endcase
  end

  assign oSDRAM_RD       = sdram_rd;
  assign oSDRAM_WR       = sdram_wr;
  assign oSDRAM_ADDR     = sdram_addr;
  assign oSDRAM_WDATA    = sdram_wdata;
  assign oA_WAIT_REQUEST = a_wait;
  assign oB_WAIT_REQUEST = b_wait;
  assign oGRANT          = grant;
  assign oPENDING_RD     = pending_q;
  assign oA_RD_DATA      = iSDRAM_RD_DATA;
  assign oA_RD_DATAVALID = iSDRAM_RD_DATAVALID;

  // b_acc only feeds the beat counter; keep it referenced for clarity of intent.
  logic unused_ok;
  assign unused_ok = b_acc;

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Self-checking bench for sdram_access_arbiter: scenario tasks plus a transaction-level
// reference model of ownership, beat budgets and outstanding reads.
module tb_sdram_access_arbiter;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;
  localparam int A_MAX  = 512;
  localparam int B_MAX  = 16;
  localparam int MAXP   = 8;

  logic              iCLK = 1'b0;
  logic              iRST;
  logic              iA_RD_EN;
  logic [ADDR_W-1:0] iA_RD_ADDR;
  logic              oA_WAIT_REQUEST;
  logic [DATA_W-1:0] oA_RD_DATA;
  logic              oA_RD_DATAVALID;
  logic              iB_WR_EN;
  logic [ADDR_W-1:0] iB_WR_ADDR;
  logic [DATA_W-1:0] iB_WR_DATA;
  logic              oB_WAIT_REQUEST;
  logic              oSDRAM_RD;
  logic              oSDRAM_WR;
  logic [ADDR_W-1:0] oSDRAM_ADDR;
  logic [DATA_W-1:0] oSDRAM_WDATA;
  logic              iSDRAM_WAIT_REQUEST;
  logic [DATA_W-1:0] iSDRAM_RD_DATA;
  logic              iSDRAM_RD_DATAVALID;
  logic [1:0]        oGRANT;
  logic [3:0]        oPENDING_RD;

  int tests_run    = 0;
  int tests_failed = 0;

  sdram_access_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .A_MAX_BEATS(A_MAX),
    .B_MAX_BEATS(B_MAX), .MAX_PENDING(MAXP)
  ) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iA_RD_EN(iA_RD_EN), .iA_RD_ADDR(iA_RD_ADDR), .oA_WAIT_REQUEST(oA_WAIT_REQUEST),
    .oA_RD_DATA(oA_RD_DATA), .oA_RD_DATAVALID(oA_RD_DATAVALID),
    .iB_WR_EN(iB_WR_EN), .iB_WR_ADDR(iB_WR_ADDR), .iB_WR_DATA(iB_WR_DATA),
    .oB_WAIT_REQUEST(oB_WAIT_REQUEST),
    .oSDRAM_RD(oSDRAM_RD), .oSDRAM_WR(oSDRAM_WR), .oSDRAM_ADDR(oSDRAM_ADDR),
    .oSDRAM_WDATA(oSDRAM_WDATA), .iSDRAM_WAIT_REQUEST(iSDRAM_WAIT_REQUEST),
    .iSDRAM_RD_DATA(iSDRAM_RD_DATA), .iSDRAM_RD_DATAVALID(iSDRAM_RD_DATAVALID),
    .oGRANT(oGRANT), .oPENDING_RD(oPENDING_RD)
  );

  always #5 iCLK = ~iCLK;

  // Reference model: who owns the bus, how many beats it has used, reads in flight.
  localparam int OWN_NONE = 0, OWN_A = 1, OWN_B = 2, OWN_DEAD = 3;
  int   m_owner, m_target, m_beats, m_pend;
  bit   m_acc_a, m_acc_b;
  logic [67:0] exp_vec;

  function automatic logic [67:0] obs();
    return {oSDRAM_RD, oSDRAM_WR, oSDRAM_ADDR, oSDRAM_WDATA, oA_WAIT_REQUEST,
            oB_WAIT_REQUEST, oGRANT, oPENDING_RD, oA_RD_DATA, oA_RD_DATAVALID};
  endfunction

  task automatic cyc_begin();
    logic e_rd, e_wr, e_aw, e_bw;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wd;
    logic [1:0] e_g;
    bit full;
    @(negedge iCLK);
    full = (m_pend >= MAXP);
    e_rd = 0; e_wr = 0; e_aw = 1; e_bw = 1; e_addr = '0; e_wd = '0; e_g = 2'b00;
    if (m_owner == OWN_A) begin
      e_g  = 2'b01;
      e_rd = iA_RD_EN && !full;
      if (e_rd) e_addr = iA_RD_ADDR;
      e_aw = full || iSDRAM_WAIT_REQUEST;
    end else if (m_owner == OWN_B) begin
      e_g  = 2'b10;
      e_wr = iB_WR_EN;
      if (e_wr) begin
        e_addr = iB_WR_ADDR;
        e_wd   = iB_WR_DATA;
      end
      e_bw = iSDRAM_WAIT_REQUEST;
    end
    m_acc_a = e_rd && !iSDRAM_WAIT_REQUEST;
    m_acc_b = e_wr && !iSDRAM_WAIT_REQUEST;
    exp_vec = {e_rd, e_wr, e_addr, e_wd, e_aw, e_bw, e_g, 4'(m_pend),
               iSDRAM_RD_DATA, iSDRAM_RD_DATAVALID};
  endtask

  task automatic cyc_end();
    @(posedge iCLK);
    if (iRST) begin
      m_owner = OWN_NONE; m_beats = 0; m_pend = 0;
    end else begin
      if (m_acc_a && !iSDRAM_RD_DATAVALID) m_pend++;
      else if (!m_acc_a && iSDRAM_RD_DATAVALID && m_pend > 0) m_pend--;
      case (m_owner)
        OWN_NONE: begin
          if (iA_RD_EN) begin m_owner = OWN_A; m_beats = 0; end
          else if (iB_WR_EN) begin m_owner = OWN_B; m_beats = 0; end
        end
        OWN_A: begin
          if (m_acc_a && m_beats < 1023) m_beats++;
          if (!iA_RD_EN) begin
            if (iB_WR_EN) begin m_owner = OWN_DEAD; m_target = OWN_B; end
            else m_owner = OWN_NONE;
          end else if (m_acc_a && m_beats == A_MAX && iB_WR_EN) begin
            m_owner = OWN_DEAD; m_target = OWN_B;
          end
        end
        OWN_B: begin
          if (m_acc_b && m_beats < 1023) m_beats++;
          if (!iB_WR_EN) begin
            if (iA_RD_EN) begin m_owner = OWN_DEAD; m_target = OWN_A; end
            else m_owner = OWN_NONE;
          end else if (m_acc_b && m_beats == B_MAX && iA_RD_EN) begin
            m_owner = OWN_DEAD; m_target = OWN_A;
          end
        end
        default: begin m_owner = m_target; m_beats = 0; end
      endcase
    end
    #1;
  endtask

  task automatic do_reset();
    iRST = 1; iA_RD_EN = 0; iB_WR_EN = 0; iA_RD_ADDR = '0; iB_WR_ADDR = '0;
    iB_WR_DATA = '0; iSDRAM_WAIT_REQUEST = 0; iSDRAM_RD_DATA = '0; iSDRAM_RD_DATAVALID = 0;
    repeat (2) begin cyc_begin(); cyc_end(); end
    iRST = 0;
  endtask

  task automatic test_reset();
    do_reset();
    cyc_begin();
    tests_run++;
    if (obs() !== exp_vec) begin tests_failed++; $display("FAIL reset_model got=%h want=%h", obs(), exp_vec); end
    tests_run++;
    if (oGRANT !== 2'b00 || oA_WAIT_REQUEST !== 1'b1 || oB_WAIT_REQUEST !== 1'b1 ||
        oSDRAM_RD !== 1'b0 || oSDRAM_WR !== 1'b0 || oPENDING_RD !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_state got grant=%b aw=%b bw=%b rd=%b wr=%b pend=%0d want 00/1/1/0/0/0",
               oGRANT, oA_WAIT_REQUEST, oB_WAIT_REQUEST, oSDRAM_RD, oSDRAM_WR, oPENDING_RD);
    end
    cyc_end();
    $display("[TB] reset checked");
  endtask

  task automatic test_basic_reads();
    int n = 0, sent = 0, peak = 0, first_g = -1, pulses = 0;
    bit acc;
    do_reset();
    iA_RD_EN = 1; iA_RD_ADDR = 25'h200;
    for (int c = 0; c < 30; c++) begin
      iSDRAM_RD_DATAVALID = (n == 4 && sent < 4);
      iSDRAM_RD_DATA = DATA_W'($urandom);
      cyc_begin();
      tests_run++;
      if (obs() !== exp_vec) begin tests_failed++; $display("FAIL basic_model c=%0d got=%h want=%h", c, obs(), exp_vec); end
      if (oGRANT == 2'b01 && first_g < 0) first_g = c;
      if (int'(oPENDING_RD) > peak) peak = int'(oPENDING_RD);
      if (oSDRAM_RD) begin
        tests_run++;
        if (oSDRAM_ADDR !== 25'h200 + 25'(pulses)) begin
          tests_failed++; $display("FAIL basic_addr got=%h want=%h", oSDRAM_ADDR, 25'h200 + 25'(pulses));
        end
        pulses++;
      end
      if (iSDRAM_RD_DATAVALID) sent++;
      acc = m_acc_a;
      cyc_end();
      if (acc) begin
        n++;
        if (n == 4) iA_RD_EN = 0; else iA_RD_ADDR = 25'h200 + 25'(n);
      end
    end
    tests_run++;
    if (first_g != 1) begin tests_failed++; $display("FAIL basic_grant_latency got=%0d want=1", first_g); end
    tests_run++;
    if (pulses != 4) begin tests_failed++; $display("FAIL basic_rd_pulses got=%0d want=4", pulses); end
    tests_run++;
    if (peak != 4) begin tests_failed++; $display("FAIL basic_pend_peak got=%0d want=4", peak); end
    tests_run++;
    if (oPENDING_RD !== 4'd0) begin tests_failed++; $display("FAIL basic_pend_end got=%0d want=0", oPENDING_RD); end
    $display("[TB] basic reads: pulses=%0d peak=%0d", pulses, peak);
  endtask

  task automatic test_handover();
    int phase = 0, a_cnt = 0, b_cnt = 0, sw1 = 0, sw2 = 0, a_issued = 0;
    logic [ADDR_W-1:0] base = 25'h0010600, resume = '0;
    bit acc_a, acc_b;
    do_reset();
    iA_RD_EN = 1; iA_RD_ADDR = base; iB_WR_EN = 1;
    iB_WR_ADDR = ADDR_W'($urandom); iB_WR_DATA = DATA_W'($urandom);
    for (int c = 0; c < 700 && phase != 5; c++) begin
      iSDRAM_RD_DATAVALID = (m_pend > 0);
      iSDRAM_RD_DATA = DATA_W'($urandom);
      cyc_begin();
      tests_run++;
      if (obs() !== exp_vec) begin tests_failed++; $display("FAIL handover_model c=%0d got=%h want=%h", c, obs(), exp_vec); end
      case (phase)
        0: if (oGRANT == 2'b01) begin phase = 1; if (oSDRAM_RD) a_cnt++; end
        1: if (oGRANT == 2'b01) begin if (oSDRAM_RD) a_cnt++; end
           else if (oGRANT == 2'b00) begin phase = 2; sw1 = 1; end else phase = 6;
        2: if (oGRANT == 2'b00) sw1++;
           else if (oGRANT == 2'b10) begin phase = 3; if (oSDRAM_WR) b_cnt++; end else phase = 6;
        3: if (oGRANT == 2'b10) begin if (oSDRAM_WR) b_cnt++; end
           else if (oGRANT == 2'b00) begin phase = 4; sw2 = 1; end else phase = 6;
        4: if (oGRANT == 2'b00) sw2++;
           else if (oGRANT == 2'b01) begin phase = 5; resume = oSDRAM_ADDR; end else phase = 6;
        default: ;
      endcase
      acc_a = m_acc_a; acc_b = m_acc_b;
      cyc_end();
      if (acc_a) begin a_issued++; iA_RD_ADDR = base + 25'(a_issued); end
      if (acc_b) begin iB_WR_ADDR = ADDR_W'($urandom); iB_WR_DATA = DATA_W'($urandom); end
    end
    tests_run++;
    if (phase != 5) begin tests_failed++; $display("FAIL handover_sequence got_phase=%0d want=5", phase); end
    tests_run++;
    if (a_cnt != A_MAX) begin tests_failed++; $display("FAIL handover_a_beats got=%0d want=%0d", a_cnt, A_MAX); end
    tests_run++;
    if (sw1 != 1 || sw2 != 1) begin tests_failed++; $display("FAIL handover_switch_cycles got=%0d/%0d want=1/1", sw1, sw2); end
    tests_run++;
    if (b_cnt != B_MAX) begin tests_failed++; $display("FAIL handover_b_beats got=%0d want=%0d", b_cnt, B_MAX); end
    tests_run++;
    if (resume !== base + 25'd512) begin tests_failed++; $display("FAIL handover_resume_addr got=%h want=%h", resume, base + 25'd512); end
    $display("[TB] handover: a=%0d b=%0d resume=%h", a_cnt, b_cnt, resume);
  endtask

  task automatic test_wait_stall();
    int a_cnt = 0;
    logic [ADDR_W-1:0] base = 25'h0200000;
    do_reset();
    iA_RD_EN = 1; iA_RD_ADDR = base; iB_WR_EN = 1; iB_WR_DATA = 16'h1234;
    for (int c = 0; c < 600 && a_cnt < A_MAX - 1; c++) begin
      iSDRAM_RD_DATAVALID = (m_pend > 0);
      cyc_begin();
      tests_run++;
      if (obs() !== exp_vec) begin tests_failed++; $display("FAIL stall_model c=%0d got=%h want=%h", c, obs(), exp_vec); end
      if (m_acc_a) a_cnt++;
      cyc_end();
      iA_RD_ADDR = base + 25'(a_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      iSDRAM_WAIT_REQUEST = 1; iSDRAM_RD_DATAVALID = (m_pend > 0);
      cyc_begin();
      tests_run++;
      if (obs() !== exp_vec) begin tests_failed++; $display("FAIL stall_model_hold k=%0d got=%h want=%h", k, obs(), exp_vec); end
      tests_run++;
      if (oA_WAIT_REQUEST !== 1'b1 || oB_WAIT_REQUEST !== 1'b1 || oGRANT !== 2'b01 ||
          oSDRAM_ADDR !== base + 25'd511) begin
        tests_failed++;
        $display("FAIL stall_hold k=%0d got aw=%b bw=%b grant=%b addr=%h want 1/1/01/%h",
                 k, oA_WAIT_REQUEST, oB_WAIT_REQUEST, oGRANT, oSDRAM_ADDR, base + 25'd511);
      end
      cyc_end();
    end
    iSDRAM_WAIT_REQUEST = 0;
    cyc_begin();
    tests_run++;
    if (oSDRAM_RD !== 1'b1 || oA_WAIT_REQUEST !== 1'b0 || oGRANT !== 2'b01) begin
      tests_failed++; $display("FAIL stall_release got rd=%b aw=%b grant=%b want 1/0/01", oSDRAM_RD, oA_WAIT_REQUEST, oGRANT);
    end
    cyc_end();
    iA_RD_ADDR = base + 25'd512;
    cyc_begin();
    tests_run++;
    if (oGRANT !== 2'b00) begin tests_failed++; $display("FAIL stall_handover got grant=%b want=00", oGRANT); end
    cyc_end();
    $display("[TB] wait stall at beat 511 checked");
  endtask

  task automatic test_throttle();
    int cnt = 0, extra = 0;
    do_reset();
    iA_RD_EN = 1; iA_RD_ADDR = 25'h40000;
    for (int c = 0; c < 20; c++) begin
      cyc_begin();
      tests_run++;
      if (obs() !== exp_vec) begin tests_failed++; $display("FAIL throttle_model c=%0d got=%h want=%h", c, obs(), exp_vec); end
      if (m_acc_a) cnt++;
      if (c == 19) begin
        tests_run++;
        if (oSDRAM_RD !== 1'b0 || oA_WAIT_REQUEST !== 1'b1 || oPENDING_RD !== 4'd8) begin
          tests_failed++; $display("FAIL throttle_block got rd=%b aw=%b pend=%0d want 0/1/8", oSDRAM_RD, oA_WAIT_REQUEST, oPENDING_RD);
        end
      end
      cyc_end();
      iA_RD_ADDR = 25'h40000 + 25'(cnt);
    end
    tests_run++;
    if (cnt != MAXP) begin tests_failed++; $display("FAIL throttle_count got=%0d want=%0d", cnt, MAXP); end
    for (int c = 0; c < 7; c++) begin
      iSDRAM_RD_DATAVALID = (c == 0);
      cyc_begin();
      tests_run++;
      if (obs() !== exp_vec) begin tests_failed++; $display("FAIL throttle_release_model c=%0d got=%h want=%h", c, obs(), exp_vec); end
      if (oSDRAM_RD && !oA_WAIT_REQUEST) extra++;
      cyc_end();
    end
    iSDRAM_RD_DATAVALID = 0;
    tests_run++;
    if (extra != 1) begin tests_failed++; $display("FAIL throttle_one_more got=%0d want=1", extra); end
    $display("[TB] throttle: accepted=%0d after_valid=%0d", cnt, extra);
  endtask

  task automatic test_pend_same_cycle();
    do_reset();
    iA_RD_EN = 1; iA_RD_ADDR = 25'h123;
    for (int c = 0; c < 20 && m_pend < 5; c++) begin
      cyc_begin();
      tests_run++;
      if (obs() !== exp_vec) begin tests_failed++; $display("FAIL same_model c=%0d got=%h want=%h", c, obs(), exp_vec); end
      cyc_end();
    end
    iSDRAM_RD_DATAVALID = 1;
    cyc_begin();
    tests_run++;
    if (oPENDING_RD !== 4'd5 || oSDRAM_RD !== 1'b1 || oA_WAIT_REQUEST !== 1'b0) begin
      tests_failed++; $display("FAIL same_setup got pend=%0d rd=%b aw=%b want 5/1/0", oPENDING_RD, oSDRAM_RD, oA_WAIT_REQUEST);
    end
    cyc_end();
    iSDRAM_RD_DATAVALID = 0; iA_RD_EN = 0;
    cyc_begin();
    tests_run++;
    if (oPENDING_RD !== 4'd5) begin tests_failed++; $display("FAIL same_cycle_pend got=%0d want=5", oPENDING_RD); end
    cyc_end();
    $display("[TB] simultaneous issue/return checked");
  endtask

  task automatic test_reset_mid_b();
    int b_cnt = 0;
    do_reset();
    iA_RD_EN = 1; iA_RD_ADDR = 25'h77;
    for (int c = 0; c < 4; c++) begin cyc_begin(); cyc_end(); end
    iA_RD_EN = 0; iB_WR_EN = 1; iB_WR_ADDR = 25'h1000; iB_WR_DATA = 16'h5A5A;
    for (int c = 0; c < 40 && b_cnt < 7; c++) begin
      cyc_begin();
      tests_run++;
      if (obs() !== exp_vec) begin tests_failed++; $display("FAIL rstb_model c=%0d got=%h want=%h", c, obs(), exp_vec); end
      if (m_acc_b) b_cnt++;
      cyc_end();
      iB_WR_ADDR = 25'h1000 + 25'(b_cnt);
    end
    tests_run++;
    if (b_cnt != 7 || oPENDING_RD !== 4'd3) begin
      tests_failed++; $display("FAIL rstb_setup got beats=%0d pend=%0d want 7/3", b_cnt, oPENDING_RD);
    end
    iRST = 1;
    cyc_begin(); cyc_end();
    iRST = 0;
    cyc_begin();
    tests_run++;
    if (obs() !== exp_vec) begin tests_failed++; $display("FAIL rstb_model_after got=%h want=%h", obs(), exp_vec); end
    tests_run++;
    if (oGRANT !== 2'b00 || oSDRAM_WR !== 1'b0 || oPENDING_RD !== 4'd0 || oB_WAIT_REQUEST !== 1'b1) begin
      tests_failed++; $display("FAIL rstb_state got grant=%b wr=%b pend=%0d bw=%b want 00/0/0/1",
                               oGRANT, oSDRAM_WR, oPENDING_RD, oB_WAIT_REQUEST);
    end
    cyc_end();
    iB_WR_EN = 0;
    $display("[TB] reset mid B burst checked");
  endtask

  task automatic test_simultaneous();
    int exp_g[8] = '{0, 1, 1, 1, 0, 2, 2, 2};
    int n = 0, wr_seen = 0;
    bit acc;
    do_reset();
    iA_RD_EN = 1; iA_RD_ADDR = 25'h300; iB_WR_EN = 1; iB_WR_ADDR = 25'h5000; iB_WR_DATA = 16'hBEEF;
    for (int c = 0; c < 8; c++) begin
      cyc_begin();
      tests_run++;
      if (obs() !== exp_vec) begin tests_failed++; $display("FAIL simul_model c=%0d got=%h want=%h", c, obs(), exp_vec); end
      tests_run++;
      if (oGRANT !== 2'(exp_g[c])) begin tests_failed++; $display("FAIL simul_grant c=%0d got=%b want=%0d", c, oGRANT, exp_g[c]); end
      if (oSDRAM_WR) begin
        wr_seen++;
        tests_run++;
        if (oSDRAM_WDATA !== 16'hBEEF) begin tests_failed++; $display("FAIL simul_wdata got=%h want=beef", oSDRAM_WDATA); end
      end
      acc = m_acc_a;
      cyc_end();
      if (acc) begin n++; iA_RD_ADDR = 25'h300 + 25'(n); if (n == 2) iA_RD_EN = 0; end
    end
    tests_run++;
    if (wr_seen != 3) begin tests_failed++; $display("FAIL simul_writes got=%0d want=3", wr_seen); end
    iB_WR_EN = 0;
    $display("[TB] simultaneous requests: A reads=%0d B writes=%0d", n, wr_seen);
  endtask

  task automatic test_random();
    int errs = 0;
    bit acc_a, acc_b;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      iRST = ($urandom_range(0, 499) == 0);
      iSDRAM_WAIT_REQUEST = ($urandom_range(0, 3) == 0);
      iSDRAM_RD_DATAVALID = (m_pend > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0);
      iSDRAM_RD_DATA = DATA_W'($urandom);
      cyc_begin();
      tests_run++;
      if (obs() !== exp_vec) begin
        tests_failed++; errs++;
        if (errs < 10) $display("FAIL random_model c=%0d got=%h want=%h", c, obs(), exp_vec);
      end
      acc_a = m_acc_a; acc_b = m_acc_b;
      cyc_end();
      if (acc_a || !iA_RD_EN) begin
        iA_RD_EN = ($urandom_range(0, 3) != 0); iA_RD_ADDR = ADDR_W'($urandom);
      end
      if (acc_b || !iB_WR_EN) begin
        iB_WR_EN = ($urandom_range(0, 2) != 0);
        iB_WR_ADDR = ADDR_W'($urandom); iB_WR_DATA = DATA_W'($urandom);
      end
    end
    iRST = 0;
    $display("[TB] random traffic: model errors=%0d", errs);
  endtask

  initial begin
    m_owner = OWN_NONE; m_target = OWN_NONE; m_beats = 0; m_pend = 0;
    m_acc_a = 0; m_acc_b = 0; exp_vec = '0;
    test_reset();
    test_basic_reads();
    test_handover();
    test_wait_stall();
    test_throttle();
    test_pend_same_cycle();
    test_reset_mid_b();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sdram_access_arbiter.md
Name: sdram_access_arbiter

Overview:
Shares the single SDRAM controller Avalon-style master port between two requesters. Port A is the real-time VGA line fetcher (read-only). Port B is the frame uploader that writes pattern frames into SDRAM (write-only). Port A has priority. Bounded grant lengths keep port B from starving, and an outstanding-read limiter throttles port A. The block sits between the SDRAM-to-VGA FIFO loader / frame uploader and the SDRAM controller.

Parameters:
ADDR_W, 25, SDRAM word address width ({frame_id[5:0], line[9:0], word[8:0]}).
DATA_W, 16, SDRAM data width.
A_MAX_BEATS, 512, accepted A reads before a forced hand-over to a waiting B (one full 1024-pixel line).
B_MAX_BEATS, 16, accepted B writes before a forced hand-over to a waiting A.
MAX_PENDING, 8, maximum A reads issued but not yet returned; 1..15.

Ports:
iCLK  in  1  system/SDRAM clock; all logic on its rising edge.
iRST  in  1  synchronous, active-high reset.
iA_RD_EN  in  1  A read request; held with its address until accepted.
iA_RD_ADDR  in  ADDR_W  A read address.
oA_WAIT_REQUEST  out  1  A command not accepted this cycle.
oA_RD_DATA  out  DATA_W  read data to A (iSDRAM_RD_DATA passthrough).
oA_RD_DATAVALID  out  1  read data valid (iSDRAM_RD_DATAVALID passthrough).
iB_WR_EN  in  1  B write request; held with address and data until accepted.
iB_WR_ADDR  in  ADDR_W  B write address.
iB_WR_DATA  in  DATA_W  B write data.
oB_WAIT_REQUEST  out  1  B command not accepted this cycle.
oSDRAM_RD  out  1  read command to the controller.
oSDRAM_WR  out  1  write command to the controller.
oSDRAM_ADDR  out  ADDR_W  command address.
oSDRAM_WDATA  out  DATA_W  write data.
iSDRAM_WAIT_REQUEST  in  1  controller stall.
iSDRAM_RD_DATA  in  DATA_W  controller read data.
iSDRAM_RD_DATAVALID  in  1  controller read data valid.
oGRANT  out  2  {B granted, A granted}; 2'b00 in IDLE and SWITCH.
oPENDING_RD  out  4  outstanding A read count.

Behaviour:
- States: ST_IDLE=0, ST_GRANT_A=1, ST_GRANT_B=2, ST_SWITCH=3. The state register, switch target, beat counter (10 bit) and pending counter are all registered.
- Command path is combinational from the granted port:
  - GRANT_A: oSDRAM_RD = iA_RD_EN && !throttle, where throttle = (pending == MAX_PENDING). oSDRAM_ADDR = iA_RD_ADDR.
  - GRANT_B: oSDRAM_WR = iB_WR_EN. oSDRAM_ADDR = iB_WR_ADDR. oSDRAM_WDATA = iB_WR_DATA.
  - Otherwise oSDRAM_RD = oSDRAM_WR = 0. oSDRAM_ADDR and oSDRAM_WDATA are 0 whenever no command is driven.
- Wait requests:
  - oA_WAIT_REQUEST = !(GRANT_A && !throttle && !iSDRAM_WAIT_REQUEST).
  - oB_WAIT_REQUEST = !(GRANT_B && !iSDRAM_WAIT_REQUEST).
  - A non-granted port always sees wait = 1.
- Accepted beat: the granted port's enable is high, its forwarded command is high, and iSDRAM_WAIT_REQUEST is 0.
- Beat counter: cleared on every grant entry, +1 per accepted beat, saturates at 1023.
- Transitions:
  - IDLE: iA_RD_EN -> GRANT_A; else iB_WR_EN -> GRANT_B; else stay. A request therefore sees its first forward one cycle after assertion.
  - GRANT_A, A enable low: -> SWITCH(target B) if iB_WR_EN, else -> IDLE.
  - GRANT_A, A beat accepted with beat_next == A_MAX_BEATS and iB_WR_EN high: -> SWITCH(target B). If B is not waiting, the counter keeps counting (saturating) and A keeps the grant.
  - GRANT_B: symmetric, using B_MAX_BEATS and iA_RD_EN.
  - SWITCH: exactly one dead cycle, then -> target grant, even if the target has dropped its request. The new grant then exits on the next cycle per the rules above.
  - A forced hand-over happens only on an accepted-beat cycle, so no un-accepted command is ever abandoned.
- Pending counter: +1 on an accepted A read, −1 on iSDRAM_RD_DATAVALID, unchanged when both occur. It never decrements below 0; stray valids after reset are still passed through.
- Read data passes through in all states, including SWITCH and GRANT_B.
- Reset (synchronous, any state, including mid-burst): state IDLE, beat counter 0, pending 0, oGRANT 0, both wait requests 1, oSDRAM_RD/WR 0.
- Simultaneous A and B requests in IDLE: A wins.

Test Plan:
- Reset, then A requests 4 reads at addrs 0x0000200..203 with SDRAM wait low -> oGRANT=01 the cycle after iA_RD_EN; 4 oSDRAM_RD pulses with matching addresses; oPENDING_RD peaks at 4 and returns to 0 after 4 data valids.
- A continuous reads with B waiting from cycle 0 -> exactly 512 A reads accepted, 1 SWITCH cycle with oGRANT=00, then 16 B writes, 1 SWITCH, A resumes at word 512.
- iSDRAM_WAIT_REQUEST held high for 3 cycles mid-A burst while B waits, at beat 511 -> both waits high; address stable; no hand-over until beat 512 is accepted.
- Data valid withheld, A keeps requesting -> after 8 accepted reads oSDRAM_RD=0 and oA_WAIT_REQUEST=1; one data valid -> exactly one more read accepted.
- Accepted read and data valid in the same cycle with pending=5 -> pending stays 5. iRST asserted mid-B burst (beat 7) -> next cycle oGRANT=00, oSDRAM_WR=0, oPENDING_RD=0.
- A and B assert together in IDLE, A drops after 2 reads -> GRANT_A, 2 reads, SWITCH, GRANT_B; B writes with data 0xBEEF appear on oSDRAM_WDATA.
